cplx_mac_core: RTL and testbench

Parametrised signed complex multiply-accumulate core with valid/ready operand and result interfaces. Successor of the fixed complex multiplier: adds two's-complement operands, a selectable multiplier count (1/2/4) with a resource-shared schedule, frame accumulation, and optional saturation. Sits between the operand source and the result sink of the complex datapath; one instance replaces the per-`NO_MULT` multiplier variants.

---
 rtl/cplx_mac_pkg.sv | 19 +
 rtl/cplx_mac_acc.sv | 32 +++
 rtl/cplx_mac_core.sv | 188 ++++++++++++++++++
 tb/tb_cplx_mac_core.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cplx_mac_pkg.sv
// Shared types and constants for the signed complex multiply-accumulate core.
// Saturation is controlled by the CPLX_MAC_SAT_EN macro (see cplx_mac_acc).
package cplx_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_OUT  = 2'd2
    } cplx_mac_state_e;

    // Product order: 0 x1*x2 (+re), 1 y1*y2 (-re), 2 x1*y2 (+im), 3 y1*x2 (+im)
    localparam logic [3:0] PROD_NEG = 4'b0010;
    localparam logic [3:0] PROD_IM  = 4'b1100;

    function automatic int calc_awidth(input int dwidth, input int guard);
        return 2 * dwidth + 1 + guard;
    endfunction

endpackage

// File: rtl/cplx_mac_acc.sv
// Adds one sign-extended product term into one accumulator component.
// CPLX_MAC_SAT_EN defined: clamp to the signed AWIDTH range; otherwise wrap.
module cplx_mac_acc #(
    parameter int AWIDTH = 21,
    parameter int TWIDTH = 17
) (
    input  logic signed [AWIDTH-1:0] acc_in,
    input  logic signed [TWIDTH-1:0] term,
    output logic signed [AWIDTH-1:0] acc_out,
    output logic                     sat
);

`ifdef CPLX_MAC_SAT_EN
    logic signed [AWIDTH:0] full;

    always_comb begin
        full = (AWIDTH+1)'(acc_in) + (AWIDTH+1)'(term);
        sat  = full[AWIDTH] ^ full[AWIDTH-1];
        if (sat) begin
            acc_out = {full[AWIDTH], {(AWIDTH-1){~full[AWIDTH]}}};
        end else begin
            acc_out = full[AWIDTH-1:0];
        end
    end
`else
    always_comb begin
        acc_out = acc_in + AWIDTH'(term);
        sat     = 1'b0;
    end
`endif

endmodule

// File: rtl/cplx_mac_core.sv
// Signed complex MAC core: NO_MULT products per cycle over K=4/NO_MULT cycles,
// frame accumulation, valid/ready handshakes. Optional saturation: CPLX_MAC_SAT_EN.
module cplx_mac_core
    import cplx_mac_pkg::*;
#(
    parameter int DWIDTH    = 8,
    parameter int NO_MULT   = 2,
    parameter int ACC_GUARD = 4
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         sw_rst,
    input  logic                                         op_val,
    output logic                                         op_rdy,
    input  logic [4*DWIDTH-1:0]                          op_data,
    input  logic                                         op_acc,
    input  logic                                         op_last,
    output logic                                         res_val,
    input  logic                                         res_rdy,
    output logic [2*calc_awidth(DWIDTH, ACC_GUARD)-1:0]  res_data,
    output logic                                         res_sat
);

    localparam int          AWIDTH    = calc_awidth(DWIDTH, ACC_GUARD);
    localparam int          TWIDTH    = 2 * DWIDTH + 1;
    localparam int unsigned NO_MULT_U = NO_MULT;
    localparam int unsigned K         = 4 / NO_MULT;
    localparam logic [1:0]  LAST_STEP = 2'(K - 1);

    if (NO_MULT != 1 && NO_MULT != 2 && NO_MULT != 4) begin : g_bad_no_mult
        $error("cplx_mac_core: NO_MULT must be 1, 2 or 4");
    end

    cplx_mac_state_e            state_q, state_d;
    logic [1:0]                 step_q, step_d;
    logic [4*DWIDTH-1:0]        ops_q, ops_d;
    logic                       acc_mode_q, acc_mode_d;
    logic                       last_q, last_d;
    logic signed [AWIDTH-1:0]   acc_re_q, acc_re_d, acc_im_q, acc_im_d;
    logic                       res_val_q, res_val_d;
    logic [2*AWIDTH-1:0]        res_data_q, res_data_d;
    logic                       res_sat_q, res_sat_d;

    logic signed [DWIDTH-1:0]   x1, y1, x2, y2;
    logic signed [TWIDTH-1:0]   term_re, term_im;
    logic signed [AWIDTH-1:0]   sum_re, sum_im;
    logic                       sat_re, sat_im;

    assign x1 = ops_q[4*DWIDTH-1:3*DWIDTH];
    assign y1 = ops_q[3*DWIDTH-1:2*DWIDTH];
    assign x2 = ops_q[2*DWIDTH-1:DWIDTH];
    assign y2 = ops_q[DWIDTH-1:0];

    // Multiplier m in step s handles product index s*NO_MULT+m; same-target
    // products of one cycle are pre-summed so each accumulator sees one add.
    always_comb begin
        logic [1:0]                 idx;
        logic signed [2*DWIDTH-1:0] prod;
        logic signed [TWIDTH-1:0]   ext;
        term_re = '0;
        term_im = '0;
        idx     = '0;
        prod    = '0;
        ext     = '0;
        for (int unsigned m = 0; m < NO_MULT_U; m++) begin
            idx = 2'(int'(step_q) * NO_MULT + int'(m));
            case (idx)
                2'd0:    prod = (2*DWIDTH)'(x1) * (2*DWIDTH)'(x2);
                2'd1:    prod = (2*DWIDTH)'(y1) * (2*DWIDTH)'(y2);
                2'd2:    prod = (2*DWIDTH)'(x1) * (2*DWIDTH)'(y2);
                default: prod = (2*DWIDTH)'(y1) * (2*DWIDTH)'(x2);
            endcase
            ext = TWIDTH'(prod);
            if (PROD_NEG[idx]) ext = -ext;
            if (PROD_IM[idx]) term_im = term_im + ext;
            else              term_re = term_re + ext;
        end
    end

    cplx_mac_acc #(.AWIDTH(AWIDTH), .TWIDTH(TWIDTH)) u_acc_re (
        .acc_in (acc_re_q),
        .term   (term_re),
        .acc_out(sum_re),
        .sat    (sat_re)
    );

    cplx_mac_acc #(.AWIDTH(AWIDTH), .TWIDTH(TWIDTH)) u_acc_im (
        .acc_in (acc_im_q),
        .term   (term_im),
        .acc_out(sum_im),
        .sat    (sat_im)
    );

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        ops_d      = ops_q;
        acc_mode_d = acc_mode_q;
        last_d     = last_q;
        acc_re_d   = acc_re_q;
        acc_im_d   = acc_im_q;
        res_val_d  = res_val_q;
        res_data_d = res_data_q;
        res_sat_d  = res_sat_q;
        if (sw_rst) begin
            state_d    = ST_IDLE;
            step_d     = '0;
            ops_d      = '0;
            acc_mode_d = 1'b0;
            last_d     = 1'b0;
            acc_re_d   = '0;
            acc_im_d   = '0;
            res_val_d  = 1'b0;
            res_data_d = '0;
            res_sat_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (op_val) begin
                        ops_d      = op_data;
                        acc_mode_d = op_acc;
                        last_d     = op_last;
                        step_d     = '0;
                        state_d    = ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc_re_d  = sum_re;
                    acc_im_d  = sum_im;
                    res_sat_d = res_sat_q | sat_re | sat_im;
                    step_d    = step_q + 2'd1;
                    if (step_q == LAST_STEP) begin
                        step_d = '0;
                        if (!acc_mode_q || last_q) begin
                            res_data_d = {sum_re, sum_im};
                            res_val_d  = 1'b1;
                            state_d    = ST_OUT;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_OUT: begin
                    if (res_rdy) begin
                        res_val_d = 1'b0;
                        acc_re_d  = '0;
                        acc_im_d  = '0;
                        res_sat_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            ops_q      <= '0;
            acc_mode_q <= 1'b0;
            last_q     <= 1'b0;
            acc_re_q   <= '0;
            acc_im_q   <= '0;
            res_val_q  <= 1'b0;
            res_data_q <= '0;
            res_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            ops_q      <= ops_d;
            acc_mode_q <= acc_mode_d;
            last_q     <= last_d;
            acc_re_q   <= acc_re_d;
            acc_im_q   <= acc_im_d;
            res_val_q  <= res_val_d;
            res_data_q <= res_data_d;
            res_sat_q  <= res_sat_d;
        end
    end

    assign op_rdy   = (state_q == ST_IDLE);
    assign res_val  = res_val_q;
    assign res_data = res_data_q;
    assign res_sat  = res_sat_q;

endmodule

// File: tb/tb_cplx_mac_core.sv
// Scoreboard bench for cplx_mac_core: three instances (NO_MULT 4/1/2, the last
// with ACC_GUARD=0 for saturation). Honours CPLX_MAC_SAT_EN when defined.
module tb_cplx_mac_core;

    localparam int AW_A = 21;
    localparam int AW_C = 17;
`ifdef CPLX_MAC_SAT_EN
    localparam int T6_IM  = 65535;
    localparam bit T6_SAT = 1'b1;
`else
    localparam int T6_IM  = -65536;
    localparam bit T6_SAT = 1'b0;
`endif

    typedef struct {
        int re;
        int im;
        bit sat;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0, sw_rst = 1'b0;
    logic op_val = 1'b0, op_acc = 1'b0, op_last = 1'b0, res_rdy = 1'b1;
    logic [31:0] op_data = '0;
    int sel = 0;
    logic [2:0] op_val_v, op_rdy_v, res_val_v, res_sat_v;
    logic [2*AW_A-1:0] rd0, rd1;
    logic [2*AW_C-1:0] rd2;
    exp_t q0[$], q1[$], q2[$];
    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    assign op_val_v[0] = op_val && (sel == 0);
    assign op_val_v[1] = op_val && (sel == 1);
    assign op_val_v[2] = op_val && (sel == 2);

    cplx_mac_core #(.DWIDTH(8), .NO_MULT(4), .ACC_GUARD(4)) u_m4 (
        .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst), .op_val(op_val_v[0]), .op_rdy(op_rdy_v[0]),
        .op_data(op_data), .op_acc(op_acc), .op_last(op_last), .res_val(res_val_v[0]),
        .res_rdy(res_rdy), .res_data(rd0), .res_sat(res_sat_v[0]));

    cplx_mac_core #(.DWIDTH(8), .NO_MULT(1), .ACC_GUARD(4)) u_m1 (
        .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst), .op_val(op_val_v[1]), .op_rdy(op_rdy_v[1]),
        .op_data(op_data), .op_acc(op_acc), .op_last(op_last), .res_val(res_val_v[1]),
        .res_rdy(res_rdy), .res_data(rd1), .res_sat(res_sat_v[1]));

    cplx_mac_core #(.DWIDTH(8), .NO_MULT(2), .ACC_GUARD(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst), .op_val(op_val_v[2]), .op_rdy(op_rdy_v[2]),
        .op_data(op_data), .op_acc(op_acc), .op_last(op_last), .res_val(res_val_v[2]),
        .res_rdy(res_rdy), .res_data(rd2), .res_sat(res_sat_v[2]));

    function automatic int re_of(input int d);
        case (d)
            0:       return int'($signed(rd0[2*AW_A-1:AW_A]));
            1:       return int'($signed(rd1[2*AW_A-1:AW_A]));
            default: return int'($signed(rd2[2*AW_C-1:AW_C]));
        endcase
    endfunction

    function automatic int im_of(input int d);
        case (d)
            0:       return int'($signed(rd0[AW_A-1:0]));
            1:       return int'($signed(rd1[AW_A-1:0]));
            default: return int'($signed(rd2[AW_C-1:0]));
        endcase
    endfunction

    function automatic logic [31:0] pk(input int x1, input int y1, input int x2, input int y2);
        return {x1[7:0], y1[7:0], x2[7:0], y2[7:0]};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: a result handshake completes at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        bit   have;
        if (rst_n && !sw_rst) begin
            for (int d = 0; d < 3; d++) begin
                if (res_val_v[d] && res_rdy) begin
                    have = 1'b0;
                    case (d)
                        0: if (q0.size() > 0) begin have = 1'b1; e = q0.pop_front(); end
                        1: if (q1.size() > 0) begin have = 1'b1; e = q1.pop_front(); end
                        default: if (q2.size() > 0) begin have = 1'b1; e = q2.pop_front(); end
                    endcase
                    if (!have) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_result dut%0d: got re=%0d im=%0d, expected none",
                                 d, re_of(d), im_of(d));
                    end else begin
                        chk($sformatf("dut%0d.re", d), re_of(d), e.re);
                        chk($sformatf("dut%0d.im", d), im_of(d), e.im);
                        chk($sformatf("dut%0d.sat", d), int'(res_sat_v[d]), int'(e.sat));
                    end
                end
            end
        end
    end

    task automatic send(input int d, input logic [31:0] data, input bit acc, input bit last);
        int t = 0;
        sel = d; op_data = data; op_acc = acc; op_last = last; op_val = 1'b1;
        while (!op_rdy_v[d] && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout dut%0d: op_rdy got 0, expected 1", d);
        end
        @(posedge clk); #1;
        op_val = 1'b0;
    endtask

    task automatic wait_res(input int d, input int k, input string name);
        int lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!res_val_v[d] && lat < 20);
        chk(name, lat, k);
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_op_rdy%0d", d), int'(op_rdy_v[d]), 1);
            chk($sformatf("rst_res_val%0d", d), int'(res_val_v[d]), 0);
            chk($sformatf("rst_res_sat%0d", d), int'(res_sat_v[d]), 0);
            chk($sformatf("rst_re%0d", d), re_of(d), 0);
            chk($sformatf("rst_im%0d", d), im_of(d), 0);
        end

        // 1: NO_MULT=4, single op
        q0.push_back('{2, 16, 1'b0});
        send(0, pk(2, 3, 4, 2), 1'b0, 1'b0);
        wait_res(0, 1, "t1_latency");

        // 2: signed corners on NO_MULT=1
        q1.push_back('{32385, -127, 1'b0});
        send(1, pk(127, -128, 127, 127), 1'b0, 1'b0);
        wait_res(1, 4, "t2a_latency");
        q1.push_back('{0, 32768, 1'b0});
        send(1, pk(-128, -128, -128, -128), 1'b0, 1'b0);
        wait_res(1, 4, "t2b_latency");

        // 3: accumulation frame of three (1+i)^2
        q0.push_back('{0, 6, 1'b0});
        for (int i = 0; i < 2; i++) begin
            send(0, pk(1, 1, 1, 1), 1'b1, 1'b0);
            repeat (3) begin @(posedge clk); #1; end
            chk($sformatf("t3_no_res%0d", i), int'(res_val_v[0]), 0);
            chk($sformatf("t3_idle%0d", i), int'(op_rdy_v[0]), 1);
        end
        send(0, pk(1, 1, 1, 1), 1'b1, 1'b1);
        wait_res(0, 1, "t3_latency");

        // 4: backpressure
        repeat (2) begin @(posedge clk); #1; end
        res_rdy = 1'b0;
        q0.push_back('{2, 16, 1'b0});
        send(0, pk(2, 3, 4, 2), 1'b0, 1'b0);
        wait_res(0, 1, "t4_latency");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("t4_hold_val", int'(res_val_v[0]), 1);
            chk("t4_hold_op_rdy", int'(op_rdy_v[0]), 0);
            chk("t4_hold_re", re_of(0), 2);
            chk("t4_hold_im", im_of(0), 16);
        end
        res_rdy = 1'b1;
        @(posedge clk); #1;
        chk("t4_op_rdy_after", int'(op_rdy_v[0]), 1);
        chk("t4_res_val_after", int'(res_val_v[0]), 0);

        // 5: sw_rst abort in the 2nd CALC cycle of NO_MULT=1
        repeat (2) begin @(posedge clk); #1; end
        send(1, pk(2, 3, 4, 2), 1'b0, 1'b0);
        @(posedge clk); #1;
        sw_rst = 1'b1;
        @(posedge clk); #1;
        sw_rst = 1'b0;
        chk("t5_op_rdy", int'(op_rdy_v[1]), 1);
        for (int i = 0; i < 6; i++) begin
            chk("t5_no_res", int'(res_val_v[1]), 0);
            @(posedge clk); #1;
        end
        q1.push_back('{2, 16, 1'b0});
        send(1, pk(2, 3, 4, 2), 1'b0, 1'b0);
        wait_res(1, 4, "t5_latency");

        // 6: saturation/wrap with ACC_GUARD=0, then sat cleared on the next frame
        q2.push_back('{0, T6_IM, T6_SAT});
        send(2, pk(-128, -128, -128, -128), 1'b1, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        chk("t6_no_res", int'(res_val_v[2]), 0);
        send(2, pk(-128, -128, -128, -128), 1'b1, 1'b1);
        wait_res(2, 2, "t6_latency");
        q2.push_back('{0, 2, 1'b0});
        send(2, pk(1, 1, 1, 1), 1'b0, 1'b0);
        wait_res(2, 2, "t6b_latency");

        t = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("scoreboard_drained", q0.size() + q1.size() + q2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
